// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the ROM from a fetch PC and buffers {pc, instr}
// pairs in a small in-order prefetch FIFO for the downstream consumer.
// Optional feature macro: FETCH_FAULT_EN (alignment and range fault detection).
module instruction_fetch_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [31:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc_plus4,
  output logic                  fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]           fetch_pc;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  fault;
  logic [31:0]           pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic        pop;
  logic        push_req;
  logic        push;
  logic        fault_set;
  logic        redirect_bad;
  logic        range_bad;
  logic [31:0] target;

`ifdef FETCH_FAULT_EN
  // Misaligned targets and fetches outside the ROM window raise a sticky fault.
  always_comb begin
    redirect_bad = (redirect_pc[1:0] != 2'b00);
    range_bad    = (fetch_pc[31:8] != PC_RESET[31:8]);
    target       = redirect_pc;
  end
  assign fetch_fault = fault;
`else
  // Without fault detection the low target bits are forced to word alignment.
  always_comb begin
    redirect_bad = 1'b0;
    range_bad    = 1'b0;
    target       = redirect_pc & 32'hFFFF_FFFC;
  end
  assign fetch_fault = 1'b0;
`endif

  // Handshake decode: a redirect suppresses the push but never the pop.
  always_comb begin
    pop       = out_valid && out_ready;
    push_req  = !redirect_valid && !fault && ((count != FULL) || pop);
    push      = push_req && !range_bad;
    fault_set = (redirect_valid && redirect_bad) || (push_req && range_bad);
  end

  // Control state: fetch PC, occupancy, pointers and the sticky fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= PC_RESET;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fault    <= 1'b0;
    end else begin
      if (fault_set) fault <= 1'b1;
      if (redirect_valid) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= target;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Buffer storage; occupancy bookkeeping makes reset of the payload unnecessary.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= rom_q;
    end
  end

  assign rom_addr     = fetch_pc;
  assign out_valid    = (count != '0);
  assign out_pc       = out_valid ? pc_mem[rd_ptr] : 32'd0;
  assign out_pc_plus4 = out_valid ? (pc_mem[rd_ptr] + 32'd4) : 32'd0;
  assign out_instr    = out_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit (default build, DEPTH=2).
module tb_instruction_fetch_unit;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_q;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_q = rom_word(rom_addr);

  instruction_fetch_unit #(
    .DATA_WIDTH(32),
    .PC_RESET(PC_RST),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rom_addr(rom_addr),
    .rom_q(rom_q),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Expected program-order stream starting at a given address.
  task automatic reload(input logic [31:0] start);
    exp_t e;
    logic [31:0] p;
    sb.delete();
    p = start;
    for (int i = 0; i < 16; i++) begin
      e.pc = p;
      e.instr = rom_word(p);
      sb.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // Scoreboard monitor: compares every accepted head, reloads on flush stimulus.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got pc %h with no expected entry left", out_pc);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || out_pc_plus4 !== (e.pc + 32'd4)) begin
          miscompares++;
          $display("FAIL sb_head: got pc %h instr %h pc4 %h, expected pc %h instr %h pc4 %h",
                   out_pc, out_instr, out_pc_plus4, e.pc, e.instr, e.pc + 32'd4);
        end
      end
    end
    if (!reset && out_valid === 1'b0) begin
      vectors++;
      if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_pc_plus4 !== 32'd0) begin
        miscompares++;
        $display("FAIL idle_zero: got pc %h instr %h pc4 %h, expected all 0",
                 out_pc, out_instr, out_pc_plus4);
      end
    end
    if (reset) reload(PC_RST);
    else if (redirect_valid) reload(redirect_pc & 32'hFFFF_FFFC);
  end

  // Drive one cycle of inputs at the falling edge; returns before the next rising edge.
  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset = r;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #2;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_1000);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_pc !== 32'd0 || out_instr !== 32'd0 || out_pc_plus4 !== 32'd0) begin
      miscompares++; $display("FAIL reset_outs: got pc %h instr %h pc4 %h expected 0", out_pc, out_instr, out_pc_plus4);
    end
    vectors++;
    if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    vectors++;
    if (rom_addr !== PC_RST) begin miscompares++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, PC_RST); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'd0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== PC_RST) begin
        miscompares++; $display("FAIL stall_head[%0d]: got valid %b pc %h expected 1 %h", i, out_valid, out_pc, PC_RST);
      end
      vectors++;
      if (i == 0 && rom_addr !== 32'h0040_0004) begin
        miscompares++; $display("FAIL stall_addr0: got %h expected 00400004", rom_addr);
      end else if (i > 0 && rom_addr !== 32'h0040_0008) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got %h expected 00400008", i, rom_addr);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
    end
  endtask

  task automatic test_redirect_full();
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0040_0040);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_before_redirect: got %b expected 1", out_valid); end
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b0 || rom_addr !== 32'h0040_0040) begin
      miscompares++; $display("FAIL redirect_flush: got valid %b addr %h expected 0 00400040", out_valid, rom_addr);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0040_0040) begin
      miscompares++; $display("FAIL redirect_latency: got valid %b pc %h expected 1 00400040", out_valid, out_pc);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_redirect_pop();
    cyc(1'b0, 1'b1, 1'b1, 32'h0040_0100);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_pop_flush: got %b expected 0", out_valid); end
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_wrap();
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      vectors++;
      if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL wrap_fault[%0d]: got %b expected 0", i, fetch_fault); end
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b0, 1'b0, 1'b1, 32'h0040_0042);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (rom_addr !== 32'h0040_0040) begin miscompares++; $display("FAIL misalign_addr: got %h expected 00400040", rom_addr); end
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    vectors++;
    if (out_pc !== 32'h0040_0040 || fetch_fault !== 1'b0) begin
      miscompares++; $display("FAIL misalign_head: got pc %h fault %b expected 00400040 0", out_pc, fetch_fault);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_reset_fill: got %b expected 1", out_valid); end
    cyc(1'b1, 1'b1, 1'b1, 32'h0040_0200);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    vectors++;
    if (out_valid !== 1'b0 || rom_addr !== PC_RST) begin
      miscompares++; $display("FAIL mid_reset: got valid %b addr %h expected 0 %h", out_valid, rom_addr, PC_RST);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_stream();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_misaligned();
    test_mid_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-002 Parameter PC_RESET, default 32'h0040_0000, SHALL set the fetch PC after reset.
REQ-003 Parameter DEPTH, default 2, SHALL set the prefetch buffer entries; legal values are 2 and 4.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port rom_addr, output, 32: byte address to the instruction ROM; SHALL be driven combinationally from the fetch PC register.
REQ-008 Port rom_q, input, DATA_WIDTH: ROM word; combinational, valid in the same cycle as rom_addr.
REQ-009 Port redirect_valid, input, 1: branch/jump request.
REQ-010 Port redirect_pc, input, 32: branch/jump target address.
REQ-011 Port out_valid, output, 1: the buffer head holds an instruction.
REQ-012 Port out_ready, input, 1: the consumer accepts the head.
REQ-013 Port out_instr, output, DATA_WIDTH: head instruction.
REQ-014 Port out_pc, output, 32: address of the head instruction.
REQ-015 Port out_pc_plus4, output, 32: out_pc + 4, modulo 2^32.
REQ-016 Port fetch_fault, output, 1: sticky fetch fault (see Configuration).

Function
REQ-017 The block SHALL hold a FIFO of {pc, instr} entries with DEPTH entries and a count of 0..DEPTH.
REQ-018 out_valid SHALL equal (count != 0).
REQ-019 When out_valid=0, out_instr, out_pc and out_pc_plus4 SHALL be driven to 0.
REQ-020 A pop SHALL occur on an edge where out_valid && out_ready.
REQ-021 A push SHALL occur on an edge where redirect_valid=0, fault is clear, and (count < DEPTH or a pop occurs); the push SHALL write {fetch_pc, rom_q} and set fetch_pc <= fetch_pc + 4.
REQ-022 A simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-023 When the buffer is full and no pop occurs, fetch_pc and the buffer contents SHALL hold.
REQ-024 fetch_pc SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-025 redirect_valid SHALL have the highest priority: count <= 0 and fetch_pc <= redirect_pc, with no push on that edge.
REQ-026 A pop coincident with a redirect SHALL count as completed for the consumer, and the flush SHALL still apply.
REQ-027 Latency: for a redirect sampled at edge N, the target is pushed at edge N+1 and out_valid=1 after edge N+1.
REQ-028 Steady-state throughput SHALL be one instruction per cycle while out_ready=1.
REQ-029 Buffer entry order SHALL be strict program order; no entry is lost or duplicated across full/empty transitions.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set fetch_pc <= PC_RESET, count <= 0 and fault <= 0.
REQ-031 Reset SHALL take priority over redirect_valid, push and pop.
REQ-032 After reset the outputs SHALL be: out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fetch_fault=0, rom_addr=PC_RESET.
REQ-033 Reset asserted mid-stream SHALL discard all buffered entries.
REQ-034 The first instruction (PC_RESET) SHALL be valid after the first edge with reset=0.

Configuration
REQ-035 Macro FETCH_FAULT_EN, when defined: a redirect with redirect_pc[1:0] != 0, or a push with fetch_pc[31:8] != PC_RESET[31:8], SHALL set fault.
REQ-036 With FETCH_FAULT_EN defined, fault SHALL be sticky until reset, fetch_fault SHALL be 1, pushes SHALL stop, and buffered entries SHALL still drain.
REQ-037 With FETCH_FAULT_EN undefined: redirect_pc[1:0] SHALL be treated as 00, no range check SHALL be made, and fetch_fault SHALL be tied to 0.

Verification
REQ-038 Reset release with ROM words W0..W3 and out_ready=1 -> out_pc = 0x00400000, 0x00400004, ... on consecutive cycles, with out_instr = W0, W1, ...
REQ-039 out_ready=0 for 5 cycles (DEPTH=2) -> count saturates at 2, rom_addr holds at 0x00400008, then resumes with no gap or duplicate.
REQ-040 Redirect to 0x00400040 while the buffer is full -> the next valid out_pc is 0x00400040 two edges later, and the stale entries never appear.
REQ-041 Redirect with redirect_pc=0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC then 0x00000000; FETCH_FAULT_EN undefined shows no fault; FETCH_FAULT_EN defined asserts fetch_fault.
REQ-042 With FETCH_FAULT_EN defined, redirect to 0x00400042 -> fetch_fault=1 on the next cycle, out_valid=0 after draining, and cleared only by reset.
REQ-043 Reset asserted with count=2 and redirect_valid=1 -> after the edge, out_valid=0 and rom_addr=0x00400000.
